rf_debug_port: RTL and testbench
================================

# rf_debug_port

Debug responder that gives an external host (bench, JTAG shim, or SoC bus bridge) architectural access to the RV32I pipeline's register file through a valid/ready request/response interface. For each access it halts the pipeline, waits for it to drain, reads the register file through a dedicated read port, and returns the value. It sits beside `RV32I_Pipline`, driving the core's halt input and the register file's third read port. In-system register checks therefore need no hierarchical peeks.

## Interface
Parameters:
- `HALT_TIMEOUT`, 64: maximum cycles to wait for `halted` before failing the request.
- `XLEN`, 32: data width.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  host request valid.
- `req_ready`  out  1  high only in IDLE.
- `req_cmd`  in  2  command: 00 READ, 01 HALT, 10 RESUME, 11 illegal.
- `req_addr`  in  5  register index, used by READ only.
- `rsp_valid`  out  1  response valid; held until `rsp_ready`.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_data`  out  XLEN  read data; 0 for non-READ commands or on error.
- `rsp_err`  out  1  1 on timeout or illegal command.
- `halt_req`  out  1  request to the core to stop fetch and drain.
- `halted`  in  1  core drained, with no register-file writes in flight.
- `rf_raddr`  out  5  debug read address into the register file.
- `rf_rdata`  in  XLEN  combinational read data for `rf_raddr`.

## Operation
- States: IDLE, WAIT_HALT, READ, RESP.
- Sticky flag `sess_halt` is set by a successful HALT and cleared by RESUME.
- A request is accepted on `req_valid && req_ready`. The command and address are registered at acceptance.
- READ:
  - If `halted` is high at acceptance, go to READ; otherwise go to WAIT_HALT.
  - In READ, `rf_raddr` = the latched address. At the end of the cycle `rsp_data` ← `rf_rdata`, or 0 if the address is 0. Then go to RESP.
- HALT: go to WAIT_HALT. On `halted`, set `sess_halt` and go to RESP with data 0.
- RESUME: clear `sess_halt` and go directly to RESP with `rsp_err`=0.
- Illegal command: go directly to RESP with `rsp_err`=1. State and `sess_halt` are unchanged.
- WAIT_HALT:
  - The counter starts at 0 on entry and increments each cycle that `halted` is low.
  - If the counter reaches `HALT_TIMEOUT`, go to RESP with `rsp_err`=1 and `rsp_data`=0. `sess_halt` is not set.
- RESP: when `rsp_valid && rsp_ready`, return to IDLE.
- `halt_req` is a registered output. It is high when `sess_halt` is set, or while state ∈ {WAIT_HALT, READ, RESP} for a READ or HALT command. An auto-halt for READ drops on the cycle after the handshake if `sess_halt` is 0.
- Counter width: $clog2(HALT_TIMEOUT+1).

## Timing
- Reset values: `req_ready`=0 while `rst` is high, then 1 in IDLE. `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `halt_req`=0, `rf_raddr`=0. `sess_halt` is cleared.
- READ while already halted: `rsp_valid` rises 2 cycles after the accept edge.
- READ while not halted: `halt_req` rises 1 cycle after accept. `rsp_valid` rises 2 cycles after the first edge at which `halted` is sampled high.
- RESUME and illegal commands: `rsp_valid` rises 1 cycle after accept.
- A response handshake in the same cycle as a new `req_valid`: the request is not accepted, because `req_ready` is low in RESP. It is accepted one cycle later.
- `halted` dropping during READ or RESP does not change the captured data.
- `rst` asserted mid-operation: next edge goes to IDLE, with `halt_req` low and any response discarded.
- `rsp_*` outputs are stable while `rsp_valid && !rsp_ready`.

## Structure
- Shared package `rv32_pkg` holds `dbg_cmd_e` (READ/HALT/RESUME/ILLEGAL) and `dbg_state_e`.
- Single module; no sub-module needed.
- The timeout counter stays inline.
- The register file gains a third combinational read port; the core gains the `halt_req`/`halted` pair.

## Test plan
- Run the hazard program to completion, then HALT, then READ x9 → `rsp_data`=0x0000002A, `rsp_err`=0. READ x28 → 0x0000012A.
- READ x8 with `halted` tied to rise 5 cycles after `halt_req` → `rsp_valid` 7 cycles after `halt_req` rises, data 0x00000100. `halt_req` drops after the handshake.
- READ x0 after writing anything → `rsp_data`=0.
- `halted` held low, `HALT_TIMEOUT`=8 → `rsp_err`=1 and `rsp_data`=0, 9 cycles after accept. `halt_req` low after the handshake.
- HALT, then hold `rsp_ready` low for 10 cycles → `rsp_*` stable. Then RESUME → `halt_req` low 1 cycle after the RESUME response handshake. Command 11 → `rsp_err`=1.
- Assert `rst` during WAIT_HALT → next cycle in IDLE, `halt_req`=0, `rsp_valid`=0.

Source files
------------

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Purpose  : Shared types for the RV32I pipeline debug infrastructure.
//            dbg_cmd_e   - host command encoding on the debug request channel
//            dbg_state_e - sequencing states of the register-file debug port
// Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

   typedef enum logic [1:0] {
      CMD_READ    = 2'b00,
      CMD_HALT    = 2'b01,
      CMD_RESUME  = 2'b10,
      CMD_ILLEGAL = 2'b11
   } dbg_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_WAIT_HALT = 2'b01,
      ST_READ      = 2'b10,
      ST_RESP      = 2'b11
   } dbg_state_e;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rf_debug_port.sv
`default_nettype none
// ============================================================================
// Module   : rf_debug_port
// Purpose  : Debug responder giving a host architectural access to the RV32I
//            register file. Each READ halts the pipeline, waits for it to
//            drain, reads through a dedicated register-file port and returns
//            the value. HALT/RESUME control a sticky session halt.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/ready     - host request handshake
//            req_cmd, req_addr   - command (READ/HALT/RESUME/illegal), index
//            rsp_valid/ready     - response handshake
//            rsp_data, rsp_err   - read data / error flag
//            halt_req, halted    - core halt request and drained status
//            rf_raddr, rf_rdata  - debug read port into the register file
// Revision : 1.0 - initial release
// ============================================================================
module rf_debug_port
   import rv32_pkg::*;
#(
   parameter int HALT_TIMEOUT = 64,
   parameter int XLEN         = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_cmd,
   input  logic [4:0]      req_addr,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic            rsp_err,
   output logic            halt_req,
   input  logic            halted,
   output logic [4:0]      rf_raddr,
   input  logic [XLEN-1:0] rf_rdata
);

   localparam int                c_cnt_w    = $clog2(HALT_TIMEOUT + 1);
   // Timeout fires on the cycle the counter would reach HALT_TIMEOUT.
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HALT_TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   dbg_state_e          state_q,     state_d;
   dbg_cmd_e            cmd_q,       cmd_d;
   logic [4:0]          addr_q,      addr_d;
   logic                sess_halt_q, sess_halt_d;
   logic [c_cnt_w-1:0]  cnt_q,       cnt_d;
   logic [XLEN-1:0]     rsp_data_q,  rsp_data_d;
   logic                rsp_err_q,   rsp_err_d;
   logic                halt_req_q,  halt_req_d;
   logic                w_accept;

   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign halt_req  = halt_req_q;
   assign rf_raddr  = (state_q == ST_READ) ? addr_q : 5'd0;
   assign w_accept  = req_valid && req_ready;

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      addr_d      = addr_q;
      sess_halt_d = sess_halt_q;
      cnt_d       = cnt_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               cmd_d      = dbg_cmd_e'(req_cmd);
               addr_d     = req_addr;
               cnt_d      = '0;
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               case (dbg_cmd_e'(req_cmd))
                  CMD_READ:   state_d = halted ? ST_READ : ST_WAIT_HALT;
                  CMD_HALT:   state_d = ST_WAIT_HALT;
                  CMD_RESUME: begin
                     sess_halt_d = 1'b0;
                     state_d     = ST_RESP;
                  end
                  default: begin
                     rsp_err_d = 1'b1;
                     state_d   = ST_RESP;
                  end
               endcase
            end
         end
         ST_WAIT_HALT: begin
            if (halted) begin
               if (cmd_q == CMD_READ) begin
                  state_d = ST_READ;
               end else begin
                  sess_halt_d = 1'b1;
                  state_d     = ST_RESP;
               end
            end else if (cnt_q == c_cnt_last) begin
               rsp_err_d  = 1'b1;
               rsp_data_d = '0;
               state_d    = ST_RESP;
            end else begin
               cnt_d = cnt_q + c_cnt_one;
            end
         end
         ST_READ: begin
            // x0 is architecturally zero regardless of what the port returns.
            rsp_data_d = (addr_q == 5'd0) ? '0 : rf_rdata;
            state_d    = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered from next-state values so halt_req rises the cycle after
      // accept and an auto-halt drops the cycle after the response handshake.
      halt_req_d = sess_halt_d ||
                   ((state_d != ST_IDLE) &&
                    ((cmd_d == CMD_READ) || (cmd_d == CMD_HALT)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cmd_q       <= CMD_READ;
         addr_q      <= 5'd0;
         sess_halt_q <= 1'b0;
         cnt_q       <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         halt_req_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         sess_halt_q <= sess_halt_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         halt_req_q  <= halt_req_d;
      end
   end

endmodule : rf_debug_port
`default_nettype wire

// File: tb/tb_rf_debug_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_debug_port
// Purpose  : Directed self-checking bench for rf_debug_port. A small register
//            file array stands in for the core's third read port and the
//            bench drives `halted` directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_debug_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_cmd;
   logic [4:0]  req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        halt_req;
   logic        halted;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;

   logic [31:0] rf [32];

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   always_comb rf_rdata = rf[rf_raddr];

   rf_debug_port #(
      .HALT_TIMEOUT(8),
      .XLEN        (32)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_cmd  (req_cmd),
      .req_addr (req_addr),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data (rsp_data),
      .rsp_err  (rsp_err),
      .halt_req (halt_req),
      .halted   (halted),
      .rf_raddr (rf_raddr),
      .rf_rdata (rf_rdata)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] cmd, input logic [4:0] addr);
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_addr  = addr;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total_cnt++;
      if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else pass_cnt++;
      total_cnt++;
      if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
      total_cnt++;
      if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else pass_cnt++;
      total_cnt++;
      if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b want 0", rsp_err); else pass_cnt++;
      total_cnt++;
      if (halt_req !== 1'b0) $display("FAIL reset_halt_req: got %b want 0", halt_req); else pass_cnt++;
      total_cnt++;
      if (rf_raddr !== 5'd0) $display("FAIL reset_rf_raddr: got %0d want 0", rf_raddr); else pass_cnt++;
      rst = 1'b0;
      #1;
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", req_ready); else pass_cnt++;
   endtask

   // HALT with the core already drained, READ x9 and x28, then RESUME.
   task automatic test_read_halted();
      halted = 1'b1;
      issue(2'b01, 5'd0);
      total_cnt++;
      if (halt_req !== 1'b1) $display("FAIL halt_cmd_halt_req: got %b want 1", halt_req); else pass_cnt++;
      tick();
      total_cnt++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0})
         $display("FAIL halt_cmd_rsp: got v=%b e=%b d=%h want v=1 e=0 d=0", rsp_valid, rsp_err, rsp_data);
      else pass_cnt++;
      handshake();

      issue(2'b00, 5'd9);
      total_cnt++;
      if ({rsp_valid, rf_raddr} !== {1'b0, 5'd9})
         $display("FAIL read_x9_stage: got v=%b raddr=%0d want v=0 raddr=9", rsp_valid, rf_raddr);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0000_002A})
         $display("FAIL read_x9_rsp: got v=%b e=%b d=%h want v=1 e=0 d=0000002a", rsp_valid, rsp_err, rsp_data);
      else pass_cnt++;
      handshake();
      total_cnt++;
      if (halt_req !== 1'b1) $display("FAIL sess_halt_hold: got %b want 1", halt_req); else pass_cnt++;

      issue(2'b00, 5'd28);
      tick();
      // Core status and register contents move while the response is pending.
      halted  = 1'b0;
      rf[28]  = 32'hFFFF_FFFF;
      tick();
      total_cnt++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0000_012A})
         $display("FAIL read_x28_rsp: got v=%b e=%b d=%h want v=1 e=0 d=0000012a", rsp_valid, rsp_err, rsp_data);
      else pass_cnt++;
      handshake();
      rf[28] = 32'h0000_012A;
      halted = 1'b1;

      issue(2'b10, 5'd0);
      total_cnt++;
      if ({rsp_valid, rsp_err, rsp_data, halt_req} !== {1'b1, 1'b0, 32'h0, 1'b0})
         $display("FAIL resume_rsp: got v=%b e=%b d=%h hr=%b want v=1 e=0 d=0 hr=0", rsp_valid, rsp_err, rsp_data, halt_req);
      else pass_cnt++;
      handshake();
      halted = 1'b0;
   endtask

   // READ x8 with the core draining 5 cycles after halt_req rises.
   task automatic test_read_wait();
      int n;
      total_cnt++;
      if (halt_req !== 1'b0) $display("FAIL wait_pre_halt_req: got %b want 0", halt_req); else pass_cnt++;
      issue(2'b00, 5'd8);
      total_cnt++;
      if (halt_req !== 1'b1) $display("FAIL wait_halt_req_rise: got %b want 1", halt_req); else pass_cnt++;
      n = 0;
      while (!rsp_valid && n < 30) begin
         if (n == 5) halted = 1'b1;
         tick();
         n++;
         if (n == 6) begin
            total_cnt++;
            if (rf_raddr !== 5'd8) $display("FAIL wait_rf_raddr: got %0d want 8", rf_raddr); else pass_cnt++;
         end
      end
      total_cnt++;
      if (n != 7) $display("FAIL wait_rsp_latency: got %0d want 7", n); else pass_cnt++;
      total_cnt++;
      if ({rsp_valid, rsp_err, rsp_data, halt_req} !== {1'b1, 1'b0, 32'h0000_0100, 1'b1})
         $display("FAIL wait_rsp: got v=%b e=%b d=%h hr=%b want v=1 e=0 d=00000100 hr=1", rsp_valid, rsp_err, rsp_data, halt_req);
      else pass_cnt++;
      handshake();
      total_cnt++;
      if (halt_req !== 1'b0) $display("FAIL wait_halt_req_drop: got %b want 0", halt_req); else pass_cnt++;
      halted = 1'b0;
   endtask

   task automatic test_read_x0();
      rf[0]  = 32'hDEAD_BEEF;
      halted = 1'b1;
      issue(2'b00, 5'd0);
      tick();
      total_cnt++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0})
         $display("FAIL read_x0_rsp: got v=%b e=%b d=%h want v=1 e=0 d=0", rsp_valid, rsp_err, rsp_data);
      else pass_cnt++;
      handshake();
      halted = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      req_valid = 1'b1;
      req_cmd   = 2'b00;
      req_addr  = 5'd9;
      tick();
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 30) begin
         tick();
         n++;
      end
      total_cnt++;
      if (n != 9) $display("FAIL timeout_latency: got %0d want 9", n); else pass_cnt++;
      total_cnt++;
      if ({rsp_valid, rsp_err, rsp_data, halt_req} !== {1'b1, 1'b1, 32'h0, 1'b1})
         $display("FAIL timeout_rsp: got v=%b e=%b d=%h hr=%b want v=1 e=1 d=0 hr=1", rsp_valid, rsp_err, rsp_data, halt_req);
      else pass_cnt++;
      handshake();
      total_cnt++;
      if (halt_req !== 1'b0) $display("FAIL timeout_halt_req_drop: got %b want 0", halt_req); else pass_cnt++;
   endtask

   task automatic test_resp_stall();
      halted = 1'b1;
      issue(2'b01, 5'd0);
      tick();
      for (int i = 0; i < 10; i++) begin
         total_cnt++;
         if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL stall_rsp_cycle%0d: got v=%b e=%b d=%h want v=1 e=0 d=0", i, rsp_valid, rsp_err, rsp_data);
         else pass_cnt++;
         tick();
      end
      handshake();
      total_cnt++;
      if ({rsp_valid, halt_req} !== {1'b0, 1'b1})
         $display("FAIL stall_after_hs: got v=%b hr=%b want v=0 hr=1", rsp_valid, halt_req);
      else pass_cnt++;
   endtask

   // Illegal command with a halt session open, then RESUME presented in the
   // same cycle as the illegal response handshake.
   task automatic test_illegal_back_to_back();
      issue(2'b11, 5'd3);
      total_cnt++;
      if ({rsp_valid, rsp_err, rsp_data, halt_req} !== {1'b1, 1'b1, 32'h0, 1'b1})
         $display("FAIL illegal_rsp: got v=%b e=%b d=%h hr=%b want v=1 e=1 d=0 hr=1", rsp_valid, rsp_err, rsp_data, halt_req);
      else pass_cnt++;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_cmd   = 2'b10;
      req_addr  = 5'd0;
      total_cnt++;
      if (req_ready !== 1'b0) $display("FAIL b2b_ready_in_resp: got %b want 0", req_ready); else pass_cnt++;
      tick();
      rsp_ready = 1'b0;
      total_cnt++;
      if ({rsp_valid, req_ready, halt_req} !== {1'b0, 1'b1, 1'b1})
         $display("FAIL b2b_idle: got v=%b rdy=%b hr=%b want v=0 rdy=1 hr=1", rsp_valid, req_ready, halt_req);
      else pass_cnt++;
      tick();
      req_valid = 1'b0;
      total_cnt++;
      if ({rsp_valid, rsp_err, halt_req} !== {1'b1, 1'b0, 1'b0})
         $display("FAIL b2b_resume_rsp: got v=%b e=%b hr=%b want v=1 e=0 hr=0", rsp_valid, rsp_err, halt_req);
      else pass_cnt++;
      handshake();
      total_cnt++;
      if (halt_req !== 1'b0) $display("FAIL resume_halt_req_low: got %b want 0", halt_req); else pass_cnt++;
      halted = 1'b0;
   endtask

   task automatic test_reset_mid();
      issue(2'b00, 5'd9);
      tick();
      tick();
      total_cnt++;
      if (halt_req !== 1'b1) $display("FAIL rstmid_pre_halt_req: got %b want 1", halt_req); else pass_cnt++;
      rst = 1'b1;
      tick();
      total_cnt++;
      if ({rsp_valid, halt_req, req_ready} !== {1'b0, 1'b0, 1'b0})
         $display("FAIL rstmid_state: got v=%b hr=%b rdy=%b want v=0 hr=0 rdy=0", rsp_valid, halt_req, req_ready);
      else pass_cnt++;
      rst = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      total_cnt++;
      if ({rsp_valid, halt_req, req_ready} !== {1'b0, 1'b0, 1'b1})
         $display("FAIL rstmid_discard: got v=%b hr=%b rdy=%b want v=0 hr=0 rdy=1", rsp_valid, halt_req, req_ready);
      else pass_cnt++;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_cmd   = 2'b00;
      req_addr  = 5'd0;
      rsp_ready = 1'b0;
      halted    = 1'b0;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      // Register state left behind by the hazard program.
      rf[8]  = 32'h0000_0100;
      rf[9]  = 32'h0000_002A;
      rf[28] = 32'h0000_012A;

      test_reset();
      test_read_halted();
      test_read_wait();
      test_read_x0();
      test_timeout();
      test_resp_stall();
      test_illegal_back_to_back();
      test_reset_mid();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_rf_debug_port
`default_nettype wire
